hub75_capture: RTL and testbench

Synthesizable receiver for the LED-matrix interface that the Connect4 top level drives (clko, R1/G1/B1, R2/G2/B2, ABCD, La, En). It deserializes the panel shift stream, latches each row pair into an internal frame store, and exposes a registered pixel read port plus protocol-error flags. It serves as the panel end of the link: a loopback target on hardware and a scoreboard source in benches.

---
 rtl/hub75_capture_if.sv | 17 +
 rtl/hub75_capture.sv | 139 +++++++++++++
 tb/tb_hub75_capture.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_capture_if.sv
// HUB75 panel link: shift clock, two colour triplets, row-pair address, latch and blanking.
// master is the panel driver, slave is the receiving panel end.
interface hub75_capture_if;
  logic       clko;
  logic       R1;
  logic       G1;
  logic       B1;
  logic       R2;
  logic       G2;
  logic       B2;
  logic [3:0] ABCD;
  logic       La;
  logic       En;

  modport master (output clko, R1, G1, B1, R2, G2, B2, ABCD, La, En);
  modport slave  (input  clko, R1, G1, B1, R2, G2, B2, ABCD, La, En);
endinterface

// File: rtl/hub75_capture.sv
// HUB75 panel receiver: deserializes the shift stream into a frame store, exposes a
// registered pixel read port and sticky protocol-error flags.
module hub75_capture #(
  parameter int unsigned COLS     = 32,
  parameter int unsigned ROWPAIRS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  hub75_capture_if.slave                panel,
  input  logic [$clog2(2*ROWPAIRS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0]       rd_col,
  output logic [2:0]                    rd_rgb,
  output logic                          frame_done,
  output logic                          len_err,
  output logic                          blank_err,
  input  logic                          err_clr
);

  localparam int unsigned Rows = 2 * ROWPAIRS;
  localparam int unsigned RowW = $clog2(Rows);
  localparam int unsigned CntW = $clog2(COLS + 2);

  typedef logic [COLS-1:0][2:0] row_t;

  logic            clko_q, clko_d, clko_q2, clko_d2;
  logic            la_q, la_d, la_q2, la_d2;
  logic            en_q, en_d;
  logic [3:0]      abcd_q, abcd_d;
  logic [2:0]      rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  row_t            upper_q, upper_d, lower_q, lower_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  row_t [Rows-1:0] frame_q, frame_d;
  logic            done_pend_q, done_pend_d;
  logic            frame_done_q, frame_done_d;
  logic            len_err_q, len_err_d;
  logic            blank_err_q, blank_err_d;
  logic [2:0]      rd_rgb_q, rd_rgb_d;

  logic            shift_rise, latch_rise, row_ok, len_set, blank_set;
  logic [RowW-1:0] wr_up, wr_lo;

  always_comb begin
    clko_d  = panel.clko;
    la_d    = panel.La;
    en_d    = panel.En;
    abcd_d  = panel.ABCD;
    rgb1_d  = {panel.R1, panel.G1, panel.B1};
    rgb2_d  = {panel.R2, panel.G2, panel.B2};
    clko_d2 = clko_q;
    la_d2   = la_q;

    shift_rise = clko_q & ~clko_q2;
    latch_rise = la_q & ~la_q2;
    row_ok     = 32'(abcd_q) < ROWPAIRS;
    wr_up      = RowW'(abcd_q);
    wr_lo      = wr_up + RowW'(ROWPAIRS);

    // Newest pixel enters the top column; the first one shifted ends at column 0.
    upper_d = upper_q;
    lower_d = lower_q;
    if (shift_rise) begin
      upper_d = {rgb1_q, upper_q[COLS-1:1]};
      lower_d = {rgb2_q, lower_q[COLS-1:1]};
    end

    cnt_d = cnt_q;
    if (latch_rise) begin
      cnt_d = shift_rise ? CntW'(1) : '0;
    end else if (shift_rise && cnt_q != CntW'(COLS + 1)) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Latch stores the pre-shift contents even if a shift lands in the same cycle.
    frame_d = frame_q;
    if (latch_rise && row_ok) begin
      frame_d[wr_up] = upper_q;
      frame_d[wr_lo] = lower_q;
    end

    done_pend_d  = latch_rise && (32'(abcd_q) == ROWPAIRS - 1);
    frame_done_d = done_pend_q;

    len_set     = latch_rise && (cnt_q != CntW'(COLS) || !row_ok);
    blank_set   = la_q & ~en_q;
    len_err_d   = len_set | (len_err_q & ~err_clr);
    blank_err_d = blank_set | (blank_err_q & ~err_clr);

    rd_rgb_d = 3'b000;
    if (32'(rd_row) < Rows && 32'(rd_col) < COLS) begin
      rd_rgb_d = frame_q[rd_row][rd_col];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clko_q       <= 1'b0;
      clko_q2      <= 1'b0;
      la_q         <= 1'b0;
      la_q2        <= 1'b0;
      en_q         <= 1'b0;
      abcd_q       <= '0;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      upper_q      <= '0;
      lower_q      <= '0;
      cnt_q        <= '0;
      frame_q      <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      blank_err_q  <= 1'b0;
      rd_rgb_q     <= '0;
    end else begin
      clko_q       <= clko_d;
      clko_q2      <= clko_d2;
      la_q         <= la_d;
      la_q2        <= la_d2;
      en_q         <= en_d;
      abcd_q       <= abcd_d;
      rgb1_q       <= rgb1_d;
      rgb2_q       <= rgb2_d;
      upper_q      <= upper_d;
      lower_q      <= lower_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      blank_err_q  <= blank_err_d;
      rd_rgb_q     <= rd_rgb_d;
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign blank_err  = blank_err_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: random pixel streams checked against a pixel-history model
// of the panel (last COLS pixels since reset form a row at each latch).
module tb_hub75_capture;
  localparam int COLS = 32;
  localparam int RP   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rd_row, rd_col;
  logic [2:0] rd_rgb;
  logic       frame_done, len_err, blank_err, err_clr;

  hub75_capture_if pif ();

  hub75_capture #(.COLS(COLS), .ROWPAIRS(RP)) dut (
    .clk       (clk),
    .rst       (rst),
    .panel     (pif),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_rgb    (rd_rgb),
    .frame_done(frame_done),
    .len_err   (len_err),
    .blank_err (blank_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) begin
    done_cnt++;
    done_cyc = cyc;
  end

  // Reference model
  logic [2:0] exp_frame [0:2*RP-1][0:COLS-1];
  logic [2:0] hist_u[$];
  logic [2:0] hist_l[$];
  int         shifts;
  bit         exp_len, exp_blank;

  task automatic model_reset();
    for (int r = 0; r < 2 * RP; r++)
      for (int c = 0; c < COLS; c++) exp_frame[r][c] = 3'b000;
    hist_u.delete();
    hist_l.delete();
    shifts = 0;
    exp_len = 0;
    exp_blank = 0;
  endtask

  task automatic model_latch(input int row);
    int idx;
    if (shifts != COLS) exp_len = 1;
    for (int c = 0; c < COLS; c++) begin
      idx = hist_u.size() - COLS + c;
      exp_frame[row][c]      = (idx >= 0) ? hist_u[idx] : 3'b000;
      exp_frame[row + RP][c] = (idx >= 0) ? hist_l[idx] : 3'b000;
    end
    shifts = 0;
  endtask

  task automatic model_shift(input logic [2:0] u, input logic [2:0] l);
    hist_u.push_back(u);
    hist_l.push_back(l);
    if (hist_u.size() > COLS) begin
      void'(hist_u.pop_front());
      void'(hist_l.pop_front());
    end
    shifts++;
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rgb(input logic [2:0] u, input logic [2:0] l);
    {pif.R1, pif.G1, pif.B1} = u;
    {pif.R2, pif.G2, pif.B2} = l;
  endtask

  task automatic shift_px(input logic [2:0] u, input logic [2:0] l);
    set_rgb(u, l);
    pif.clko = 1'b1;
    tick();
    pif.clko = 1'b0;
    tick();
    model_shift(u, l);
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic latch_row(input int row);
    pif.ABCD = 4'(row);
    pif.La = 1'b1;
    tick();
    pif.La = 1'b0;
    tick();
    tick();
    tick();
    model_latch(row);
  endtask

  task automatic rd(input int r, input int c, output logic [2:0] v);
    rd_row = 5'(r);
    rd_col = 5'(c);
    tick();
    v = rd_rgb;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    exp_len = 0;
    exp_blank = 0;
  endtask

  // Tests
  task automatic test_reset();
    logic [2:0] v;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    rd(0, 0, v);
    n_cmp++;
    if (v !== 3'b000) begin n_bad++; $display("FAIL reset_rd00 got %b want 000", v); end
    rd(31, 31, v);
    n_cmp++;
    if (v !== 3'b000) begin n_bad++; $display("FAIL reset_rd3131 got %b want 000", v); end
    n_cmp++;
    if ({len_err, blank_err, frame_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000", {len_err, blank_err, frame_done});
    end
  endtask

  task automatic test_pattern();
    logic [2:0] v;
    done_cnt = 0;
    for (int i = 0; i < COLS; i++) shift_px((i % 2 == 0) ? 3'b100 : 3'b001, 3'b010);
    latch_row(5);
    rd(5, 0, v);
    n_cmp++;
    if (v !== 3'b100) begin n_bad++; $display("FAIL pat_rd_5_0 got %b want 100", v); end
    rd(5, 1, v);
    n_cmp++;
    if (v !== 3'b001) begin n_bad++; $display("FAIL pat_rd_5_1 got %b want 001", v); end
    rd(21, 7, v);
    n_cmp++;
    if (v !== 3'b010) begin n_bad++; $display("FAIL pat_rd_21_7 got %b want 010", v); end
    rd(5, 31, v);
    n_cmp++;
    if (v !== 3'b001) begin n_bad++; $display("FAIL pat_rd_5_31 got %b want 001", v); end
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL pat_len_err got %b want 0", len_err); end
    n_cmp++;
    if (done_cnt != 0) begin n_bad++; $display("FAIL pat_frame_done pulses %0d want 0", done_cnt); end
  endtask

  task automatic test_len_err();
    logic [2:0] v;
    shift_rand(COLS - 1);
    latch_row(3);
    n_cmp++;
    if (len_err !== 1'b1) begin n_bad++; $display("FAIL len_err_set got %b want 1", len_err); end
    for (int c = 0; c < COLS; c++) begin
      rd(3, c, v);
      n_cmp++;
      if (v !== exp_frame[3][c]) begin
        n_bad++; $display("FAIL len_row3 col %0d got %b want %b", c, v, exp_frame[3][c]);
      end
      rd(3 + RP, c, v);
      n_cmp++;
      if (v !== exp_frame[3 + RP][c]) begin
        n_bad++; $display("FAIL len_row19 col %0d got %b want %b", c, v, exp_frame[3 + RP][c]);
      end
    end
    clear_errs();
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL len_err_clr got %b want 0", len_err); end
  endtask

  task automatic test_blank();
    shift_rand(COLS);
    pif.En = 1'b0;
    latch_row(7);
    exp_blank = 1;
    n_cmp++;
    if (blank_err !== 1'b1) begin n_bad++; $display("FAIL blank_set got %b want 1", blank_err); end
    pif.En = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (blank_err !== 1'b1) begin n_bad++; $display("FAIL blank_hold got %b want 1", blank_err); end
    n_cmp++;
    if (len_err !== 1'(exp_len)) begin
      n_bad++; $display("FAIL blank_len got %b want %b", len_err, exp_len);
    end
    clear_errs();
    n_cmp++;
    if (blank_err !== 1'b0) begin n_bad++; $display("FAIL blank_clr got %b want 0", blank_err); end
  endtask

  task automatic test_same_cycle();
    logic [2:0] u, l;
    shift_rand(COLS);
    u = 3'($urandom_range(0, 7));
    l = 3'($urandom_range(0, 7));
    set_rgb(u, l);
    pif.ABCD = 4'd9;
    pif.clko = 1'b1;
    pif.La = 1'b1;
    tick();
    pif.clko = 1'b0;
    pif.La = 1'b0;
    tick();
    tick();
    tick();
    model_latch(9);
    model_shift(u, l);
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL same_len_a got %b want 0", len_err); end
    shift_rand(COLS - 1);
    latch_row(10);
    n_cmp++;
    if (len_err !== 1'(exp_len)) begin
      n_bad++; $display("FAIL same_len_b got %b want %b", len_err, exp_len);
    end
  endtask

  task automatic test_frame();
    logic [2:0] v;
    int la_cyc;
    done_cnt = 0;
    done_cyc = -1;
    la_cyc = 0;
    for (int r = 0; r < RP; r++) begin
      shift_rand(COLS);
      if (r == RP - 1) la_cyc = cyc;
      latch_row(r);
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL frame_done_pulses got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc - la_cyc != 3) begin
      n_bad++; $display("FAIL frame_done_latency got %0d want 3", done_cyc - la_cyc);
    end
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL frame_len got %b want 0", len_err); end
    for (int r = 0; r < 2 * RP; r++)
      for (int c = 0; c < COLS; c++) begin
        rd(r, c, v);
        n_cmp++;
        if (v !== exp_frame[r][c]) begin
          n_bad++; $display("FAIL frame_rd r%0d c%0d got %b want %b", r, c, v, exp_frame[r][c]);
        end
      end
  endtask

  task automatic test_reset_midrow();
    logic [2:0] v;
    shift_rand(10);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_reset();
    shift_rand(COLS);
    latch_row(2);
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL rst_len got %b want 0", len_err); end
    for (int c = 0; c < COLS; c++) begin
      rd(2, c, v);
      n_cmp++;
      if (v !== exp_frame[2][c]) begin
        n_bad++; $display("FAIL rst_row2 col %0d got %b want %b", c, v, exp_frame[2][c]);
      end
      rd(2 + RP, c, v);
      n_cmp++;
      if (v !== exp_frame[2 + RP][c]) begin
        n_bad++; $display("FAIL rst_row18 col %0d got %b want %b", c, v, exp_frame[2 + RP][c]);
      end
    end
    rd(5, 0, v);
    n_cmp++;
    if (v !== 3'b000) begin n_bad++; $display("FAIL rst_row5_cleared got %b want 000", v); end
  endtask

  initial begin
    pif.clko = 1'b0;
    pif.La = 1'b0;
    pif.En = 1'b1;
    pif.ABCD = 4'd0;
    set_rgb(3'b000, 3'b000);
    rd_row = '0;
    rd_col = '0;
    err_clr = 1'b0;
    model_reset();
    test_reset();
    test_pattern();
    test_len_err();
    test_blank();
    test_same_cycle();
    test_frame();
    test_reset_midrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached before end of tests");
    $fatal(1);
  end

endmodule
